// File: rtl/blake3_msg_sched.sv
// BLAKE3 message scheduler: issues the block words for NUM_ROUNDS rounds, permuting between rounds.
// Latency: round 0 valid the cycle after load; each Ack_I handshake advances one round in one cycle.
// Backpressure: Ack_I low stalls the current round indefinitely; Load_I honoured only in IDLE.
// Optional macro BLAKE3_MSG_SCHED_STATS_EN adds the completed-block counter Blk_Cnt_O.
module blake3_msg_sched #(
  parameter int NUM_ROUNDS = 7
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [511:0] Blk_I,
  input  logic         Load_I,
  output logic         Load_Rdy_O,
  output logic [511:0] M_O,
  output logic [2:0]   Rnd_O,
  output logic         Vld_O,
  input  logic         Ack_I,
  output logic         Done_O
`ifdef BLAKE3_MSG_SCHED_STATS_EN
  ,
  output logic [31:0]  Blk_Cnt_O
`endif
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [2:0] LAST_RND = 3'(NUM_ROUNDS - 1);

  // Permutation table, entry i at [4i+3:4i]: new word i takes old word PERM[i].
  localparam logic [63:0] PERM = {4'd8, 4'd15, 4'd14, 4'd9, 4'd5, 4'd12, 4'd11, 4'd1,
                                  4'd13, 4'd4, 4'd0, 4'd7, 4'd10, 4'd3, 4'd6, 4'd2};

  state_t         state_q, state_d;
  logic [511:0]   m_q, m_d;
  logic [2:0]     rnd_q, rnd_d;
  logic           done_q, done_d;
  logic           vld_q;
  logic           rdy_q;

  function automatic logic [511:0] permute(input logic [511:0] w);
    logic [511:0] r;
    int           src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      src = int'(PERM[4*i +: 4]);
      r[32*i +: 32] = w[32*src +: 32];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Load_I) begin
          m_d     = Blk_I;
          rnd_d   = 3'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (Ack_I) begin
          if (rnd_q == LAST_RND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            m_d   = permute(m_q);
            rnd_d = rnd_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid and ready are registered copies of the next state so no input reaches an output.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      vld_q   <= (state_d == ISSUE);
      rdy_q   <= (state_d == IDLE);
    end
  end

  assign M_O        = m_q;
  assign Rnd_O      = rnd_q;
  assign Vld_O      = vld_q;
  assign Done_O     = done_q;
  assign Load_Rdy_O = rdy_q;

`ifdef BLAKE3_MSG_SCHED_STATS_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      blk_cnt_q <= '0;
    end else if (done_q) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign Blk_Cnt_O = blk_cnt_q;
`endif

endmodule

// File: tb/tb_blake3_msg_sched.sv
// Self-checking bench for blake3_msg_sched against a word-array permutation model.
module tb_blake3_msg_sched;

  localparam int NR = 7;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic [511:0] Blk_I = '0;
  logic         Load_I = 1'b0;
  logic         Load_Rdy_O;
  logic [511:0] M_O;
  logic [2:0]   Rnd_O;
  logic         Vld_O;
  logic         Ack_I = 1'b0;
  logic         Done_O;
`ifdef BLAKE3_MSG_SCHED_STATS_EN
  logic [31:0]  Blk_Cnt_O;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int P[16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

  blake3_msg_sched #(.NUM_ROUNDS(NR)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Blk_I      (Blk_I),
    .Load_I     (Load_I),
    .Load_Rdy_O (Load_Rdy_O),
    .M_O        (M_O),
    .Rnd_O      (Rnd_O),
    .Vld_O      (Vld_O),
    .Ack_I      (Ack_I),
    .Done_O     (Done_O)
`ifdef BLAKE3_MSG_SCHED_STATS_EN
    ,
    .Blk_Cnt_O  (Blk_Cnt_O)
`endif
  );

  always #5 Clk = ~Clk;

  // Block words after r applications of the permutation.
  function automatic logic [511:0] ref_round(input logic [511:0] blk, input int r);
    logic [31:0]  w[16];
    logic [31:0]  t[16];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < 16; i++) t[i] = w[P[i]];
      w = t;
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = w[i];
    return o;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [511:0] pack_words(input int v[16]);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = 32'(v[i]);
    return b;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [511:0] blk);
    Blk_I  = blk;
    Load_I = 1'b1;
    tick();
    Load_I = 1'b0;
  endtask

  task automatic hard_reset();
    Load_I = 1'b0;
    Ack_I  = 1'b0;
    Rst    = 1'b1;
    tick();
    Rst    = 1'b0;
  endtask

  task automatic test_reset();
    logic [511:0] blk;
    #1 Rst = 1'b1;
    #1;
    checks++;
    if ({Vld_O, Rnd_O, Done_O, Load_Rdy_O} !== {1'b0, 3'd0, 1'b0, 1'b1} || M_O !== '0) begin
      fails++;
      $display("FAIL reset_state: vld=%b rnd=%0d done=%b rdy=%b m_zero=%b, required 0/0/0/1/1",
               Vld_O, Rnd_O, Done_O, Load_Rdy_O, M_O == '0);
    end else passes++;
    blk = rand_blk();
    Blk_I = blk;
    Load_I = 1'b1;
    tick();
    checks++;
    if (Vld_O !== 1'b0 || Load_Rdy_O !== 1'b1) begin
      fails++;
      $display("FAIL reset_holds: vld=%b rdy=%b, required 0 1", Vld_O, Load_Rdy_O);
    end else passes++;
    Rst = 1'b0;
    tick();
    Load_I = 1'b0;
    checks++;
    if (Vld_O !== 1'b1 || Rnd_O !== 3'd0 || M_O !== blk || Load_Rdy_O !== 1'b0) begin
      fails++;
      $display("FAIL first_edge_load: vld=%b rnd=%0d rdy=%b m_ok=%b, required 1 0 0 1",
               Vld_O, Rnd_O, Load_Rdy_O, M_O == blk);
    end else passes++;
    hard_reset();
  endtask

  task automatic test_pattern();
    int           idx[16];
    int           r1[16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};
    int           r2[16] = '{3, 4, 10, 12, 13, 2, 7, 14, 6, 5, 9, 0, 11, 15, 8, 1};
    logic [511:0] blk;
    int           dones = 0;
    for (int i = 0; i < 16; i++) idx[i] = i;
    blk = pack_words(idx);
    Ack_I = 1'b1;
    load(blk);
    for (int r = 0; r < NR; r++) begin
      if (Done_O === 1'b1) dones++;
      checks++;
      if (Vld_O !== 1'b1 || Rnd_O !== 3'(r) || M_O !== ref_round(blk, r)) begin
        fails++;
        $display("FAIL pattern_round%0d: vld=%b rnd=%0d m=%h", r, Vld_O, Rnd_O, M_O);
      end else passes++;
      if (r == 1) begin
        checks++;
        if (M_O !== pack_words(r1)) begin
          fails++;
          $display("FAIL pattern_r1_const: m=%h", M_O);
        end else passes++;
      end
      if (r == 2) begin
        checks++;
        if (M_O !== pack_words(r2)) begin
          fails++;
          $display("FAIL pattern_r2_const: m=%h", M_O);
        end else passes++;
      end
      tick();
    end
    checks++;
    if (Done_O !== 1'b1 || Vld_O !== 1'b0 || Load_Rdy_O !== 1'b1 || M_O !== ref_round(blk, NR - 1)) begin
      fails++;
      $display("FAIL pattern_done: done=%b vld=%b rdy=%b m_kept=%b, required 1 0 1 1",
               Done_O, Vld_O, Load_Rdy_O, M_O == ref_round(blk, NR - 1));
    end else passes++;
    dones++;
    Ack_I = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (Done_O === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin
      fails++;
      $display("FAIL pattern_done_once: done pulses=%0d, required 1", dones);
    end else passes++;
  endtask

  task automatic test_stall();
    logic [511:0] blk = rand_blk();
    Ack_I = 1'b0;
    load(blk);
    Ack_I = 1'b1;
    repeat (3) tick();
    Ack_I = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (Vld_O !== 1'b1 || Rnd_O !== 3'd3 || M_O !== ref_round(blk, 3)) begin
        fails++;
        $display("FAIL stall_hold%0d: vld=%b rnd=%0d, required 1 3", k, Vld_O, Rnd_O);
      end else passes++;
    end
    Ack_I = 1'b1;
    tick();
    checks++;
    if (Vld_O !== 1'b1 || Rnd_O !== 3'd4 || M_O !== ref_round(blk, 4)) begin
      fails++;
      $display("FAIL stall_resume: vld=%b rnd=%0d, required 1 4", Vld_O, Rnd_O);
    end else passes++;
    repeat (NR - 4) tick();
    checks++;
    if (Done_O !== 1'b1) begin
      fails++;
      $display("FAIL stall_done: done=%b, required 1", Done_O);
    end else passes++;
    Ack_I = 1'b0;
    tick();
  endtask

  task automatic test_load_ignored();
    logic [511:0] blk_a = rand_blk();
    logic [511:0] blk_b = rand_blk();
    Ack_I = 1'b1;
    load(blk_a);
    repeat (2) tick();
    Load_I = 1'b1;
    Blk_I  = blk_b;
    tick();
    Load_I = 1'b0;
    checks++;
    if (Rnd_O !== 3'd3 || M_O !== ref_round(blk_a, 3) || Load_Rdy_O !== 1'b0) begin
      fails++;
      $display("FAIL load_ignored: rnd=%0d rdy=%b m_from_first=%b, required 3 0 1",
               Rnd_O, Load_Rdy_O, M_O == ref_round(blk_a, 3));
    end else passes++;
    hard_reset();
  endtask

  task automatic test_reset_mid();
    logic [511:0] blk = rand_blk();
    int           dones = 0;
    Ack_I = 1'b1;
    load(blk);
    repeat (4) tick();
    Ack_I = 1'b0;
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (Vld_O !== 1'b0 || Rnd_O !== 3'd0 || Load_Rdy_O !== 1'b1 || Done_O !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: vld=%b rnd=%0d rdy=%b done=%b, required 0 0 1 0",
               Vld_O, Rnd_O, Load_Rdy_O, Done_O);
    end else passes++;
    tick();
    Rst = 1'b0;
    Ack_I = 1'b1;
    for (int k = 0; k < NR + 2; k++) begin
      tick();
      if (Done_O !== 1'b0 || Vld_O !== 1'b0) dones++;
    end
    Ack_I = 1'b0;
    checks++;
    if (dones != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: activity cycles=%0d, required 0", dones);
    end else passes++;
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk1 = rand_blk();
    logic [511:0] blk2 = rand_blk();
    hard_reset();
    Ack_I = 1'b1;
    load(blk1);
    repeat (NR) tick();
    checks++;
    if (Done_O !== 1'b1 || Load_Rdy_O !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done1: done=%b rdy=%b, required 1 1", Done_O, Load_Rdy_O);
    end else passes++;
    load(blk2);
    checks++;
    if (Vld_O !== 1'b1 || Rnd_O !== 3'd0 || M_O !== blk2) begin
      fails++;
      $display("FAIL b2b_accept: vld=%b rnd=%0d m_ok=%b, required 1 0 1", Vld_O, Rnd_O, M_O == blk2);
    end else passes++;
    repeat (NR) tick();
    checks++;
    if (Done_O !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done2: done=%b, required 1", Done_O);
    end else passes++;
    Ack_I = 1'b0;
    tick();
`ifdef BLAKE3_MSG_SCHED_STATS_EN
    checks++;
    if (Blk_Cnt_O !== 32'd2) begin
      fails++;
      $display("FAIL blk_cnt: got %0d, required 2", Blk_Cnt_O);
    end else passes++;
`endif
  endtask

  task automatic test_random();
    logic [511:0] blk;
    int           exp_rnd;
    bit           busy;
    bit           ack;
    int           cyc;
    for (int b = 0; b < 6; b++) begin
      blk = rand_blk();
      Ack_I = 1'b0;
      load(blk);
      exp_rnd = 0;
      busy = 1'b1;
      cyc = 0;
      while (busy && cyc < 200) begin
        checks++;
        if (Vld_O !== 1'b1 || Rnd_O !== 3'(exp_rnd) || M_O !== ref_round(blk, exp_rnd) || Done_O !== 1'b0) begin
          fails++;
          $display("FAIL random_b%0d_c%0d: vld=%b rnd=%0d done=%b, required 1 %0d 0",
                   b, cyc, Vld_O, Rnd_O, Done_O, exp_rnd);
        end else passes++;
        ack    = 1'($urandom_range(0, 1));
        Ack_I  = ack;
        Load_I = 1'($urandom_range(0, 1));
        Blk_I  = rand_blk();
        tick();
        cyc++;
        if (ack) begin
          if (exp_rnd == NR - 1) busy = 1'b0;
          else exp_rnd++;
        end
      end
      Load_I = 1'b0;
      Ack_I  = 1'b0;
      checks++;
      if (busy || Done_O !== 1'b1 || Vld_O !== 1'b0) begin
        fails++;
        $display("FAIL random_end_b%0d: timeout=%b done=%b vld=%b, required 0 1 0", b, busy, Done_O, Vld_O);
      end else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_stall();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/blake3_msg_sched.md
BLAKE3_MSG_SCHED -- requirements
Module: blake3_msg_sched

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 7, number of rounds issued per block, legal range 1..8.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Blk_I  input  512  message block; word i at bits [32i+31:32i].
REQ-005 SHALL have port Load_I  input  1  block-load request.
REQ-006 SHALL have port Load_Rdy_O  output  1  scheduler idle; a block is accepted when Load_I and Load_Rdy_O are both high.
REQ-007 SHALL have port M_O  output  512  message words for the current round; word i at bits [32i+31:32i].
REQ-008 SHALL have port Rnd_O  output  3  current round index.
REQ-009 SHALL have port Vld_O  output  1  M_O and Rnd_O are valid.
REQ-010 SHALL have port Ack_I  input  1  consumer takes the current round; a handshake occurs when Vld_O and Ack_I are both high.
REQ-011 SHALL have port Done_O  output  1  one-cycle pulse after the last round is acknowledged.

Function
REQ-012 SHALL implement two states: IDLE and ISSUE; Load_Rdy_O is 1 exactly in IDLE.
REQ-013 SHALL, on load acceptance in IDLE, register Blk_I unchanged into the word register, set Rnd_O=0, and enter ISSUE; Vld_O=1 from the next cycle.
REQ-014 SHALL, in ISSUE, hold M_O, Rnd_O and Vld_O stable while Ack_I=0, for any number of cycles.
REQ-015 SHALL, on a handshake with Rnd_O < NUM_ROUNDS-1, apply the BLAKE3 permutation (new[i] = old[P[i]], P = 2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8), increment Rnd_O, and keep Vld_O=1, with the new round visible the following cycle.
REQ-016 SHALL, on a handshake with Rnd_O = NUM_ROUNDS-1, return to IDLE, drive Vld_O=0 and Done_O=1 for exactly the next cycle; M_O keeps its last value.
REQ-017 SHALL ignore Load_I while in ISSUE; no state change and no loss of the current block.
REQ-018 SHALL accept a new load in the same cycle that Done_O is high, since the state is IDLE then.
REQ-019 SHALL, with NUM_ROUNDS=1, issue only round 0 and never apply the permutation.
REQ-020 SHALL drive all outputs from registers only; there is no combinational path from any input to any output.

Reset
REQ-021 SHALL, while Rst=1, force state=IDLE, M_O=0, Rnd_O=0, Vld_O=0, Done_O=0 and Load_Rdy_O=1, regardless of Clk.
REQ-022 SHALL abandon any block in progress when Rst asserts mid-ISSUE; no Done_O is issued for that block.
REQ-023 SHALL accept a load on the first rising edge after Rst deasserts.

Configuration
REQ-024 SHALL, when macro BLAKE3_MSG_SCHED_STATS_EN is defined, add output Blk_Cnt_O (32 bits, reset 0) that increments by 1 in the cycle Done_O is high and wraps from 0xFFFFFFFF to 0.
REQ-025 SHALL, without BLAKE3_MSG_SCHED_STATS_EN, omit the Blk_Cnt_O port and its counter entirely; all other behaviour is identical.

Verification
REQ-026 SHALL cover: load Blk_I with word i = i, Ack_I held 1 -> round 0 M_O = 0..15, round 1 = 2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8, round 2 = 3,4,10,12,13,2,7,14,6,5,9,0,11,15,8,1; Done_O pulses exactly once, in the cycle after round 6 is acknowledged.
REQ-027 SHALL cover: Ack_I=0 for 5 cycles during round 3 -> M_O and Rnd_O=3 remain stable; round 4 appears in the cycle after Ack_I rises.
REQ-028 SHALL cover: Load_I pulsed during round 2 with a different block -> ignored; round 3 output still derives from the first block.
REQ-029 SHALL cover: Rst asserted asynchronously during round 4 -> Vld_O=0, Rnd_O=0, Load_Rdy_O=1 immediately; no Done_O for that block.
REQ-030 SHALL cover: Load_I=1 in the Done_O cycle -> new block accepted and round 0 valid the next cycle; with BLAKE3_MSG_SCHED_STATS_EN defined, Blk_Cnt_O reads 2 after two completed blocks.
